// File: rtl/afe_link_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : afe_link_pkg
//  Description : Shared types and helpers for the AFE LVDS lane alignment
//                logic: alignment FSM state encoding, default training word,
//                and the bit-offset width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package afe_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_t;

  // Default training word sent by the AFE, MSB first.
  localparam logic [13:0] c_TRAIN_PATTERN_DEF = 14'h3F80;

  // Width of an offset that selects one of word_width bit positions.
  function automatic int offset_width(input int word_width);
    return (word_width > 2) ? $clog2(word_width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iddr_align_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : iddr_align_ctrl_if
//  Description : Lane-side bundle of the word-alignment controller.
//  Ports       : q1/q2     DDR bit pair (q1 earlier)
//                start     (re)alignment request pulse
//                train_en  training pattern present while locked
//                word_out  aligned word, MSB = oldest bit
//                word_valid, locked, align_fail, offset
//  Modports    : master = lane source / consumer, slave = controller
//  Revision    : 1.0  initial release
// ============================================================================
interface iddr_align_ctrl_if
  import afe_link_pkg::*;
#(
  parameter int WORD_WIDTH = 14
);
  localparam int OFF_W = offset_width(WORD_WIDTH);

  logic                  q1;
  logic                  q2;
  logic                  start;
  logic                  train_en;
  logic [WORD_WIDTH-1:0] word_out;
  logic                  word_valid;
  logic                  locked;
  logic                  align_fail;
  logic [OFF_W-1:0]      offset;

  modport master (
    output q1, q2, start, train_en,
    input  word_out, word_valid, locked, align_fail, offset
  );

  modport slave (
    input  q1, q2, start, train_en,
    output word_out, word_valid, locked, align_fail, offset
  );

endinterface
`default_nettype wire

// File: rtl/iddr_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : iddr_gearbox
//  Description : 1:WORD_WIDTH/2 gearbox for a DDR-sampled lane. Keeps a
//                2*WORD_WIDTH bit history, a free-running word phase, and
//                selects the candidate word at a given bit offset.
//  Ports       : clk, rst_n      clock / async active-low reset
//                i_q1, i_q2      bit pair, i_q1 older
//                i_offset        bit offset of the candidate word
//                o_strobe        high on the last phase of each word period
//                o_cand          candidate word from the registered history
//  Revision    : 1.0  initial release
// ============================================================================
module iddr_gearbox
  import afe_link_pkg::*;
#(
  parameter  int WORD_WIDTH = 14,
  localparam int OFF_W      = offset_width(WORD_WIDTH)
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  i_q1,
  input  wire logic                  i_q2,
  input  wire logic [OFF_W-1:0]      i_offset,
  output logic                       o_strobe,
  output logic [WORD_WIDTH-1:0]      o_cand
);

  localparam int                HIST_W    = 2 * WORD_WIDTH;
  localparam int                PH_W      = $clog2(WORD_WIDTH / 2);
  localparam logic [PH_W-1:0]   c_PH_LAST = PH_W'(WORD_WIDTH / 2 - 1);

  logic [HIST_W-1:0] r_sr;
  logic [PH_W-1:0]   r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr    <= '0;
      r_phase <= '0;
    end else begin
      r_sr    <= {r_sr[HIST_W-3:0], i_q1, i_q2};
      r_phase <= (r_phase == c_PH_LAST) ? '0 : r_phase + PH_W'(1);
    end
  end

  // Offsets 0..W-1 cover every bit alignment within the 2W history, so the
  // phase never needs to slip.
  assign o_strobe = (r_phase == c_PH_LAST);
  assign o_cand   = r_sr[i_offset +: WORD_WIDTH];

endmodule
`default_nettype wire

// File: rtl/iddr_align_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : iddr_align_ctrl
//  Description : Word-alignment controller for one AFE LVDS lane. Searches
//                bit offsets for the training word, verifies it, locks, and
//                then delivers aligned words with a valid strobe.
//  Ports       : clk, rst_n  clock / async active-low reset
//                bus         iddr_align_ctrl_if.slave (lane bundle)
//  Revision    : 1.0  initial release
// ============================================================================
module iddr_align_ctrl
  import afe_link_pkg::*;
#(
  parameter int                    WORD_WIDTH    = 14,
  parameter logic [WORD_WIDTH-1:0] TRAIN_PATTERN = WORD_WIDTH'(c_TRAIN_PATTERN_DEF),
  parameter int                    VERIFY_COUNT  = 16,
  parameter int                    ERR_LIMIT     = 4
) (
  input wire logic          clk,
  input wire logic          rst_n,
  iddr_align_ctrl_if.slave  bus
);

  localparam int OFF_W   = offset_width(WORD_WIDTH);
  localparam int FAIL_W  = $clog2(2 * WORD_WIDTH + 1);
  localparam int MATCH_W = 8;
  localparam int ERR_W   = 4;

  localparam logic [OFF_W-1:0]   c_OFF_LAST    = OFF_W'(WORD_WIDTH - 1);
  localparam logic [FAIL_W-1:0]  c_FAIL_MAX    = FAIL_W'(2 * WORD_WIDTH);
  localparam logic [FAIL_W-1:0]  c_FAIL_LAST   = FAIL_W'(2 * WORD_WIDTH - 1);
  localparam logic [MATCH_W-1:0] c_VERIFY_LAST = MATCH_W'(VERIFY_COUNT - 1);
  localparam logic [ERR_W-1:0]   c_ERR_LAST    = ERR_W'(ERR_LIMIT - 1);

  align_state_t          r_state;
  logic [OFF_W-1:0]      r_offset;
  logic [FAIL_W-1:0]     r_fail_cnt;
  logic [MATCH_W-1:0]    r_match_cnt;
  logic [ERR_W-1:0]      r_err_cnt;
  logic [WORD_WIDTH-1:0] r_word;
  logic                  r_valid;
  logic                  r_locked;
  logic                  r_align_fail;

  logic                  w_strobe;
  logic [WORD_WIDTH-1:0] w_cand;
  logic                  w_match;
  logic [OFF_W-1:0]      w_offset_next;

  iddr_gearbox #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_gearbox (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_q1     (bus.q1),
    .i_q2     (bus.q2),
    .i_offset (r_offset),
    .o_strobe (w_strobe),
    .o_cand   (w_cand)
  );

  assign w_match       = (w_cand == TRAIN_PATTERN);
  assign w_offset_next = (r_offset == c_OFF_LAST) ? '0 : r_offset + OFF_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_offset     <= '0;
      r_fail_cnt   <= '0;
      r_match_cnt  <= '0;
      r_err_cnt    <= '0;
      r_word       <= '0;
      r_valid      <= 1'b0;
      r_locked     <= 1'b0;
      r_align_fail <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // start wins over any strobe decision in the same cycle.
      if (bus.start) begin
        r_state      <= ST_SEARCH;
        r_offset     <= '0;
        r_fail_cnt   <= '0;
        r_match_cnt  <= '0;
        r_err_cnt    <= '0;
        r_locked     <= 1'b0;
        r_align_fail <= 1'b0;
      end else if (w_strobe) begin
        case (r_state)
          ST_IDLE: begin
          end
          ST_SEARCH: begin
            if (w_match) begin
              r_state     <= ST_VERIFY;
              r_match_cnt <= MATCH_W'(1);
            end else begin
              r_offset <= w_offset_next;
              if (r_fail_cnt != c_FAIL_MAX)
                r_fail_cnt <= r_fail_cnt + FAIL_W'(1);
              // Flag on the failing strobe that brings the count to 2W.
              if (r_fail_cnt >= c_FAIL_LAST)
                r_align_fail <= 1'b1;
            end
          end
          ST_VERIFY: begin
            if (w_match) begin
              if (r_match_cnt >= c_VERIFY_LAST) begin
                r_state      <= ST_LOCKED;
                r_locked     <= 1'b1;
                r_align_fail <= 1'b0;
                r_fail_cnt   <= '0;
                r_err_cnt    <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + MATCH_W'(1);
              end
            end else begin
              r_state  <= ST_SEARCH;
              r_offset <= w_offset_next;
            end
          end
          ST_LOCKED: begin
            if (bus.train_en && !w_match && (r_err_cnt >= c_ERR_LAST)) begin
              // Lost alignment: no word is delivered on this strobe.
              r_state   <= ST_SEARCH;
              r_offset  <= w_offset_next;
              r_locked  <= 1'b0;
              r_err_cnt <= '0;
            end else begin
              r_valid <= 1'b1;
              r_word  <= w_cand;
              if (bus.train_en)
                r_err_cnt <= w_match ? '0 : r_err_cnt + ERR_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.word_out   = r_word;
  assign bus.word_valid = r_valid;
  assign bus.locked     = r_locked;
  assign bus.align_fail = r_align_fail;
  assign bus.offset     = r_offset;

endmodule
`default_nettype wire
